// File: rtl/hamming_tx_scheduler.sv
// Byte-to-Hamming(8,4) framed serializer feeding the FSK modulator bit input.
// Each accepted byte becomes START, low-nibble codeword, high-nibble codeword, STOP.

module hamming_enc_4to7 (
  input  logic [3:0] data_i,
  output logic [7:0] code_o
);

  logic p1, p2, p3;

  assign p1     = data_i[3] ^ data_i[2] ^ data_i[0];
  assign p2     = data_i[2] ^ data_i[1] ^ data_i[0];
  assign p3     = data_i[3] ^ data_i[2] ^ data_i[1];
  assign code_o = {1'b1, p3, p2, p1, data_i};

endmodule

module hamming_tx_scheduler #(
  parameter int unsigned BIT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_in_valid,
  output logic       io_in_ready,
  input  logic [7:0] io_in_bits,
  output logic       io_tx_bit,
  output logic       io_tx_active,
  output logic       io_bit_strobe
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_LO    = 3'd2;
  localparam logic [2:0] ST_HI    = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             tx_bit_q, tx_bit_d;
  logic             active_q, active_d;
  logic             strobe_q, strobe_d;

  logic [7:0] cw_lo, cw_hi;
  logic       accept;
  logic       bit_end;

  hamming_enc_4to7 u_enc_lo (
    .data_i (byte_q[3:0]),
    .code_o (cw_lo)
  );

  hamming_enc_4to7 u_enc_hi (
    .data_i (byte_q[7:4]),
    .code_o (cw_hi)
  );

  assign accept  = (state_q == ST_IDLE) && io_in_valid;
  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    byte_d  = byte_q;

    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (accept) begin
          byte_d  = io_in_bits;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_LO;
          idx_d   = '0;
        end
      end
      ST_LO: begin
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_HI;
          end
        end
      end
      ST_HI: begin
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so the line changes on the
  // same edge the FSM enters each bit period.
  always_comb begin
    case (state_d)
      ST_START: tx_bit_d = 1'b0;
      ST_LO:    tx_bit_d = cw_lo[idx_d];
      ST_HI:    tx_bit_d = cw_hi[idx_d];
      default:  tx_bit_d = 1'b1;
    endcase
    active_d = (state_d != ST_IDLE);
    strobe_d = accept || ((state_q != ST_IDLE) && (state_q != ST_STOP) && bit_end);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      tx_bit_q <= 1'b1;
      active_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      tx_bit_q <= tx_bit_d;
      active_q <= active_d;
      strobe_q <= strobe_d;
    end
  end

  assign io_in_ready   = (state_q == ST_IDLE);
  assign io_tx_bit     = tx_bit_q;
  assign io_tx_active  = active_q;
  assign io_bit_strobe = strobe_q;

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Directed bench: four scheduler instances (BIT_CYCLES 4, 2, 3, 16) driven by a
// table of frames with hand-computed codewords, plus reset corner sequences.

module tb_hamming_tx_scheduler;

  logic       clock;
  logic       reset;
  logic       valid [4];
  logic [7:0] bits  [4];
  logic       tx    [4];
  logic       act   [4];
  logic       strb  [4];
  logic       rdy   [4];

  int pass_cnt;
  int total;
  int cyc_n;
  int last_start;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned BC = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 3 : 16;
    hamming_tx_scheduler #(.BIT_CYCLES(BC)) u_dut (
      .clock         (clock),
      .reset         (reset),
      .io_in_valid   (valid[g]),
      .io_in_ready   (rdy[g]),
      .io_in_bits    (bits[g]),
      .io_tx_bit     (tx[g]),
      .io_tx_active  (act[g]),
      .io_bit_strobe (strb[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc_n <= cyc_n + 1;

  function automatic int bc_of(input int d);
    case (d)
      0:       return 4;
      1:       return 2;
      2:       return 3;
      default: return 16;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
  endtask

  // Sends one byte on instance d and checks the whole 18-bit frame cycle by cycle.
  task automatic run_frame(input int d, input logic [7:0] b, input logic [7:0] lo,
                           input logic [7:0] hi, input bit hold, input bit scramble,
                           input logic [7:0] nxt, input string tag);
    int          bc;
    int          k;
    int          waited;
    int          line_err;
    int          strb_err;
    int          busy_err;
    logic [17:0] want_v;
    logic [17:0] got_v;
    logic        want_s;
    bc       = bc_of(d);
    line_err = 0;
    strb_err = 0;
    busy_err = 0;
    got_v    = '0;
    want_v[0]  = 1'b0;
    want_v[17] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want_v[1 + i] = lo[i];
      want_v[9 + i] = hi[i];
    end
    waited = 0;
    while (rdy[d] !== 1'b1 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (rdy[d] !== 1'b1) begin
      check({tag, "_ready_timeout"}, 32'(rdy[d]), 32'd1);
      return;
    end
    valid[d] = 1'b1;
    bits[d]  = b;
    @(negedge clock);
    last_start = cyc_n;
    if (!hold) valid[d] = 1'b0;
    for (int c = 0; c < 18 * bc; c++) begin
      k      = c / bc;
      want_s = (c % bc == 0) ? 1'b1 : 1'b0;
      if (want_s) got_v[k] = tx[d];
      if (tx[d] !== want_v[k]) line_err++;
      if (strb[d] !== want_s) strb_err++;
      if (act[d] !== 1'b1 || rdy[d] !== 1'b0) busy_err++;
      if (scramble) begin
        bits[d]  = 8'($urandom);
        valid[d] = 1'($urandom_range(0, 1));
      end
      if (c == 18 * bc - 1) begin
        valid[d] = hold;
        bits[d]  = nxt;
      end
      @(negedge clock);
    end
    check({tag, "_frame_bits"}, 32'(got_v), 32'(want_v));
    check({tag, "_line_errs"}, line_err, 0);
    check({tag, "_strobe_errs"}, strb_err, 0);
    check({tag, "_busy_errs"}, busy_err, 0);
    check({tag, "_idle_after"}, {tx[d], act[d], rdy[d], strb[d]}, 4'b1010);
  endtask

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [7:0] cw_lo;
    logic [7:0] cw_hi;
    bit         hold;
    bit         scramble;
    logic [7:0] nxt;
  } vec_t;

  vec_t vecs [7];
  int   starts [7];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idle_err;
    int idle_strb;
    pass_cnt   = 0;
    total      = 0;
    cyc_n      = 0;
    last_start = 0;
    reset      = 1'b1;
    for (int d = 0; d < 4; d++) begin
      valid[d] = 1'b0;
      bits[d]  = 8'h00;
    end

    vecs[0] = '{dut: 0, data: 8'h5A, cw_lo: 8'hBA, cw_hi: 8'hC5, hold: 0, scramble: 0, nxt: 8'h00};
    vecs[1] = '{dut: 0, data: 8'h00, cw_lo: 8'h80, cw_hi: 8'h80, hold: 1, scramble: 0, nxt: 8'hFF};
    vecs[2] = '{dut: 0, data: 8'hFF, cw_lo: 8'hFF, cw_hi: 8'hFF, hold: 0, scramble: 0, nxt: 8'h00};
    vecs[3] = '{dut: 0, data: 8'h5A, cw_lo: 8'hBA, cw_hi: 8'hC5, hold: 0, scramble: 1, nxt: 8'h00};
    vecs[4] = '{dut: 1, data: 8'hA5, cw_lo: 8'hC5, cw_hi: 8'hBA, hold: 0, scramble: 0, nxt: 8'h00};
    vecs[5] = '{dut: 2, data: 8'hA5, cw_lo: 8'hC5, cw_hi: 8'hBA, hold: 0, scramble: 0, nxt: 8'h00};
    vecs[6] = '{dut: 3, data: 8'hA5, cw_lo: 8'hC5, cw_hi: 8'hBA, hold: 0, scramble: 0, nxt: 8'h00};

    repeat (3) @(negedge clock);
    for (int d = 0; d < 4; d++)
      check($sformatf("reset_vals_d%0d", d), {tx[d], act[d], strb[d], rdy[d]}, 4'b1001);
    reset = 1'b0;

    idle_err  = 0;
    idle_strb = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (strb[0] !== 1'b0) idle_strb++;
      if (tx[0] !== 1'b1 || act[0] !== 1'b0 || rdy[0] !== 1'b1) idle_err++;
    end
    check("idle_strobes", idle_strb, 0);
    check("idle_lines", idle_err, 0);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].dut, vecs[i].data, vecs[i].cw_lo, vecs[i].cw_hi,
                vecs[i].hold, vecs[i].scramble, vecs[i].nxt, $sformatf("vec%0d", i));
      starts[i] = last_start;
    end
    check("b2b_period", starts[2] - starts[1], 18 * 4 + 1);

    // Reset mid-frame at bit 9, then a byte offered on the first free cycle.
    while (rdy[0] !== 1'b1) @(negedge clock);
    valid[0] = 1'b1;
    bits[0]  = 8'h5A;
    @(negedge clock);
    valid[0] = 1'b0;
    repeat (9 * 4) @(negedge clock);
    check("midframe_active", {act[0], rdy[0]}, 2'b10);
    reset    = 1'b1;
    valid[0] = 1'b1;
    bits[0]  = 8'h77;
    #1;
    check("async_reset_line", {tx[0], act[0]}, 2'b10);
    repeat (3) @(negedge clock);
    check("held_in_reset", {tx[0], act[0], strb[0]}, 3'b100);
    reset = 1'b0;
    run_frame(0, 8'h3C, 8'hAC, 8'hD3, 1'b0, 1'b0, 8'h00, "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
